noc_empty_endpoint: RTL and testbench
=====================================

Name: noc_empty_endpoint

Overview:
- Terminating endpoint for an unused mesh port of the 2x2 NoC; attaches to one local port of the connector, e.g. nodes (0,1) and (1,0).
- Its receive side is the connector's sender side. It sinks every flit with no backpressure, so traffic routed to an empty node never stalls the mesh.
- Its sender side drives permanent idle toward the connector.
- Adds debug counters, last-header capture and an optional protocol checker.

Parameters:
- DATA_WIDTH, default `Noc_Data_Width (32 when the macro is undefined): flit width.
- CNT_W, default 16: width of the packet and flit counters.

Ports:
- noc_clk  in  1  clock.
- noc_rst_n  in  1  asynchronous active-low reset.
- receive_valid  in  1  incoming flit valid (from connector sender_valid).
- receive_ready  out  1  sink ready.
- receive_flit  in  DATA_WIDTH  incoming flit.
- receive_is_header  in  1  flit is a packet header.
- receive_is_tail  in  1  flit is a packet tail.
- sender_valid  out  1  outgoing valid; always 0.
- sender_ready  in  1  outgoing ready; ignored.
- sender_flit  out  DATA_WIDTH  outgoing flit; always 0.
- sender_is_header  out  1  always 0.
- sender_is_tail  out  1  always 0.
- pkt_count  out  CNT_W  completed packets.
- flit_count  out  CNT_W  accepted flits.
- last_header  out  DATA_WIDTH  most recent accepted header flit.
- proto_err  out  1  sticky protocol-error flag.

Behaviour:
- Single clock domain. All registers use async active-low reset on noc_rst_n.
- Reset values: receive_ready=0, pkt_count=0, flit_count=0, last_header=0, proto_err=0, state=IDLE.
- receive_ready is a register. It goes to 1 on the first noc_clk edge after noc_rst_n deasserts and stays 1 until the next reset.
- Acceptance: accept = receive_valid & receive_ready. Nothing is buffered. Flit payload is discarded except header capture.
- Sender outputs are combinational constants 0 in all states, including reset. sender_ready has no effect.
- flit_count: +1 per accepted flit, saturating at 2^CNT_W-1 (no wrap).
- last_header: loads receive_flit on an accepted flit with receive_is_header=1.
- Packet state machine, states IDLE and BODY:
  - IDLE, accepted header with tail=1 (single-flit packet): pkt_count+1, stay IDLE.
  - IDLE, accepted header with tail=0: go to BODY.
  - BODY, accepted non-header flit with tail=1: pkt_count+1, go to IDLE.
  - BODY, accepted non-header flit with tail=0: stay BODY.
- pkt_count saturates at 2^CNT_W-1.
- Simultaneous header and tail on one flit is legal (single-flit packet).
- receive_valid with undefined companion bits while receive_ready=0: ignored.
- Reset mid-packet: state returns to IDLE and counters clear. The partial packet is not counted.

Optional Feature:
- Macro: NOC_EMPTY_PROTO_CHECK_EN.
- When defined, proto_err is set (sticky until reset) on either violation:
  - Accepted non-header flit in IDLE: flit is counted in flit_count, no packet counted, state stays IDLE.
  - Accepted header in BODY: the previous packet is abandoned (not counted) and the new header starts a packet with the normal IDLE rules.
- When undefined:
  - proto_err is constant 0.
  - A non-header flit in IDLE is treated as BODY content: a tail flit still increments pkt_count.
  - A header in BODY restarts the packet silently.

Decomposition:
- Shared package/include noc_defines:
  - `Noc_Data_Width.
  - State encoding constants NOC_PKT_IDLE/NOC_PKT_BODY.
  - Saturating-increment helper function.
- One natural sub-module, noc_pkt_tracker: packet state machine, pkt_count and proto_err. The top holds ready generation, flit_count, last_header and the idle sender tie-offs.

Test Plan:
- Reset/idle: hold noc_rst_n=0 for 100 ps, release. Required: receive_ready=0 during reset and 1 one clock later. Sender outputs stay 0 throughout, with sender_ready toggled randomly.
- Single-flit packet: header=1, tail=1, flit=0x0000_1111. Required: pkt_count=1, flit_count=1, last_header=0x0000_1111, proto_err=0.
- 4-flit packet with receive_valid gaps: header 0xA5A5_0011, two body flits, tail. Required: pkt_count=1 only after the tail, flit_count=4, receive_ready never drops.
- Protocol error (macro defined): body flit in IDLE, then header, header, tail. Required: proto_err=1 after the first flit and stays 1, pkt_count=1, flit_count=4. With the macro undefined, the same stimulus gives proto_err=0, pkt_count=1.
- Saturation with CNT_W=4: send 20 single-flit packets. Required: pkt_count=15, flit_count=15.
- Reset mid-packet: send a header, assert reset, then send header+tail. Required: pkt_count=1, state IDLE, last_header = second header.

Source files
------------

// File: rtl/noc_defines.sv
// Shared NoC definitions: default flit width, packet-state encoding and a saturating increment.
`timescale 1ns/1ps

`ifndef Noc_Data_Width
`define Noc_Data_Width 32
`endif

package noc_defines;

  localparam logic NOC_PKT_IDLE = 1'b0;
  localparam logic NOC_PKT_BODY = 1'b1;

  // Returns value+1, holding at the all-ones value of a width-bit counter (width <= 32).
  function automatic logic [31:0] sat_inc(input logic [31:0] value, input int unsigned width);
    logic [31:0] max_val;
    max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (value >= max_val) ? max_val : value + 32'd1;
  endfunction

endpackage

// File: rtl/noc_pkt_tracker.sv
// Packet framing tracker for the empty endpoint: IDLE/BODY state, completed-packet count, protocol error.
// Protocol checking is compiled in with NOC_EMPTY_PROTO_CHECK_EN.
`timescale 1ns/1ps

module noc_pkt_tracker
  import noc_defines::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             noc_clk,
  input  logic             noc_rst_n,
  input  logic             accept,
  input  logic             is_header,
  input  logic             is_tail,
  output logic [CNT_W-1:0] pkt_count,
  output logic             proto_err
);

  logic state;
  logic state_nxt;
  logic pkt_inc;
`ifdef NOC_EMPTY_PROTO_CHECK_EN
  logic err_set;
`endif

  // NOTE: every output of this block is given a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    pkt_inc   = 1'b0;
`ifdef NOC_EMPTY_PROTO_CHECK_EN
    err_set   = 1'b0;
`endif
    if (accept) begin
      if (is_header) begin
`ifdef NOC_EMPTY_PROTO_CHECK_EN
        // A header inside a packet abandons the open packet uncounted.
        if (state == NOC_PKT_BODY) err_set = 1'b1;
`endif
        if (is_tail) begin
          pkt_inc   = 1'b1;
          state_nxt = NOC_PKT_IDLE;
        end else begin
          state_nxt = NOC_PKT_BODY;
        end
      end else if (state == NOC_PKT_BODY) begin
        if (is_tail) begin
          pkt_inc   = 1'b1;
          state_nxt = NOC_PKT_IDLE;
        end
      end else begin
`ifdef NOC_EMPTY_PROTO_CHECK_EN
        err_set = 1'b1;
`else
        // Headerless flit is taken as packet content; its tail still closes a packet.
        if (is_tail) pkt_inc = 1'b1;
`endif
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      state     <= NOC_PKT_IDLE;
      pkt_count <= '0;
    end else begin
      state <= state_nxt;
      if (pkt_inc) pkt_count <= CNT_W'(sat_inc(32'(pkt_count), CNT_W));
    end
  end

`ifdef NOC_EMPTY_PROTO_CHECK_EN
  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n)   proto_err <= 1'b0;
    else if (err_set) proto_err <= 1'b1;
  end
`else
  assign proto_err = 1'b0;
`endif

endmodule

// File: rtl/noc_empty_endpoint.sv
// Terminating endpoint for an unused 2x2 mesh port: sinks all flits, drives idle, keeps debug counters.
// Optional protocol checker enabled by NOC_EMPTY_PROTO_CHECK_EN.
`timescale 1ns/1ps

module noc_empty_endpoint
  import noc_defines::*;
#(
  parameter int DATA_WIDTH = `Noc_Data_Width,
  parameter int CNT_W      = 16
) (
  input  logic                  noc_clk,
  input  logic                  noc_rst_n,
  input  logic                  receive_valid,
  output logic                  receive_ready,
  input  logic [DATA_WIDTH-1:0] receive_flit,
  input  logic                  receive_is_header,
  input  logic                  receive_is_tail,
  output logic                  sender_valid,
  input  logic                  sender_ready,
  output logic [DATA_WIDTH-1:0] sender_flit,
  output logic                  sender_is_header,
  output logic                  sender_is_tail,
  output logic [CNT_W-1:0]      pkt_count,
  output logic [CNT_W-1:0]      flit_count,
  output logic [DATA_WIDTH-1:0] last_header,
  output logic                  proto_err
);

  logic accept;
  logic unused_sender_ready;

  assign accept = receive_valid & receive_ready;

  // Ready rises on the first edge out of reset, so flits present during reset are never taken.
  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) receive_ready <= 1'b0;
    else            receive_ready <= 1'b1;
  end

  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      flit_count  <= '0;
      last_header <= '0;
    end else if (accept) begin
      flit_count <= CNT_W'(sat_inc(32'(flit_count), CNT_W));
      if (receive_is_header) last_header <= receive_flit;
    end
  end

  noc_pkt_tracker #(
    .CNT_W (CNT_W)
  ) u_tracker (
    .noc_clk   (noc_clk),
    .noc_rst_n (noc_rst_n),
    .accept    (accept),
    .is_header (receive_is_header),
    .is_tail   (receive_is_tail),
    .pkt_count (pkt_count),
    .proto_err (proto_err)
  );

  assign sender_valid     = 1'b0;
  assign sender_flit      = '0;
  assign sender_is_header = 1'b0;
  assign sender_is_tail   = 1'b0;
  assign unused_sender_ready = &{1'b0, sender_ready};

endmodule

// File: tb/tb_noc_empty_endpoint.sv
// Directed self-checking bench for noc_empty_endpoint with a scoreboard of expected counter snapshots.
`timescale 1ns/1ps

module tb_noc_empty_endpoint;
  import noc_defines::*;

  localparam int DW = 32;
  localparam int CW = 4;
  localparam logic [CW-1:0] CMAX = '1;

  logic          noc_clk = 1'b0;
  logic          noc_rst_n = 1'b0;
  logic          receive_valid = 1'b0;
  logic          receive_ready;
  logic [DW-1:0] receive_flit = '0;
  logic          receive_is_header = 1'b0;
  logic          receive_is_tail = 1'b0;
  logic          sender_valid;
  logic          sender_ready = 1'b0;
  logic [DW-1:0] sender_flit;
  logic          sender_is_header;
  logic          sender_is_tail;
  logic [CW-1:0] pkt_count;
  logic [CW-1:0] flit_count;
  logic [DW-1:0] last_header;
  logic          proto_err;

  noc_empty_endpoint #(
    .DATA_WIDTH (DW),
    .CNT_W      (CW)
  ) dut (
    .noc_clk           (noc_clk),
    .noc_rst_n         (noc_rst_n),
    .receive_valid     (receive_valid),
    .receive_ready     (receive_ready),
    .receive_flit      (receive_flit),
    .receive_is_header (receive_is_header),
    .receive_is_tail   (receive_is_tail),
    .sender_valid      (sender_valid),
    .sender_ready      (sender_ready),
    .sender_flit       (sender_flit),
    .sender_is_header  (sender_is_header),
    .sender_is_tail    (sender_is_tail),
    .pkt_count         (pkt_count),
    .flit_count        (flit_count),
    .last_header       (last_header),
    .proto_err         (proto_err)
  );

  always #5 noc_clk = ~noc_clk;

  initial begin
    forever begin
      @(negedge noc_clk);
      sender_ready = 1'($urandom_range(0, 1));
    end
  end

`ifdef NOC_EMPTY_PROTO_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  typedef struct {
    logic [CW-1:0] pkt;
    logic [CW-1:0] flit;
    logic [DW-1:0] hdr;
    logic          err;
  } exp_t;

  exp_t sb_q[$];

  int total = 0;
  int bad   = 0;

  // Reference model of the endpoint's observable counters.
  logic [CW-1:0] m_pkt;
  logic [CW-1:0] m_flit;
  logic [DW-1:0] m_hdr;
  logic          m_err;
  bit            m_in_pkt;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_sender();
    check("sender_idle", {sender_valid, sender_is_header, sender_is_tail, sender_flit}, '0);
  endtask

  task automatic model_clear();
    m_pkt = '0; m_flit = '0; m_hdr = '0; m_err = 1'b0; m_in_pkt = 1'b0;
  endtask

  task automatic model_flit(input logic hdr, input logic tail, input logic [DW-1:0] flit);
    if (m_flit != CMAX) m_flit = m_flit + 1'b1;
    if (hdr) begin
      m_hdr = flit;
      if (CHK && m_in_pkt) m_err = 1'b1;
      if (tail) begin
        if (m_pkt != CMAX) m_pkt = m_pkt + 1'b1;
        m_in_pkt = 1'b0;
      end else begin
        m_in_pkt = 1'b1;
      end
    end else if (m_in_pkt) begin
      if (tail) begin
        if (m_pkt != CMAX) m_pkt = m_pkt + 1'b1;
        m_in_pkt = 1'b0;
      end
    end else if (CHK) begin
      m_err = 1'b1;
    end else if (tail) begin
      if (m_pkt != CMAX) m_pkt = m_pkt + 1'b1;
    end
  endtask

  task automatic sb_compare();
    exp_t e;
    e = sb_q.pop_front();
    check("sb_pkt_count", pkt_count, e.pkt);
    check("sb_flit_count", flit_count, e.flit);
    check("sb_last_header", last_header, e.hdr);
    check("sb_proto_err", proto_err, e.err);
    check("sb_ready", receive_ready, 1'b1);
    check_sender();
  endtask

  task automatic send(input logic hdr, input logic tail, input logic [DW-1:0] flit);
    exp_t e;
    @(negedge noc_clk);
    receive_valid     = 1'b1;
    receive_is_header = hdr;
    receive_is_tail   = tail;
    receive_flit      = flit;
    model_flit(hdr, tail, flit);
    e.pkt = m_pkt; e.flit = m_flit; e.hdr = m_hdr; e.err = m_err;
    sb_q.push_back(e);
    @(posedge noc_clk);
    #1;
    receive_valid     = 1'b0;
    receive_is_header = 1'b0;
    receive_is_tail   = 1'b0;
    receive_flit      = '0;
    sb_compare();
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      @(posedge noc_clk);
      #1;
      check("gap_ready", receive_ready, 1'b1);
    end
  endtask

  // Reset with garbage on the receive side; none of it may be accepted.
  task automatic do_reset();
    @(negedge noc_clk);
    noc_rst_n         = 1'b0;
    receive_valid     = 1'b1;
    receive_is_header = 1'bx;
    receive_is_tail   = 1'bx;
    receive_flit      = 'x;
    model_clear();
    #0.1;
    check("rst_ready", receive_ready, 1'b0);
    check("rst_counts", {pkt_count, flit_count, last_header, proto_err}, '0);
    check_sender();
    noc_rst_n = 1'b1;
    #0.1;
    check("rel_ready_low", receive_ready, 1'b0);
    @(posedge noc_clk);
    #1;
    check("rel_ready_high", receive_ready, 1'b1);
    check("rel_no_accept", {pkt_count, flit_count, last_header}, '0);
    receive_valid     = 1'b0;
    receive_is_header = 1'b0;
    receive_is_tail   = 1'b0;
    receive_flit      = '0;
  endtask

  initial begin
    model_clear();
    #7;
    do_reset();

    // Single-flit packet.
    send(1'b1, 1'b1, 32'h0000_1111);
    check("single_pkt", pkt_count, 4'd1);
    check("single_flit", flit_count, 4'd1);
    check("single_hdr", last_header, 32'h0000_1111);
    check("single_err", proto_err, 1'b0);

    // Four-flit packet with valid gaps.
    do_reset();
    send(1'b1, 1'b0, 32'hA5A5_0011);
    gap(2);
    check("multi_pkt_open0", pkt_count, 4'd0);
    send(1'b0, 1'b0, 32'h0000_00B1);
    gap(1);
    send(1'b0, 1'b0, 32'h0000_00B2);
    gap(3);
    check("multi_pkt_open1", pkt_count, 4'd0);
    send(1'b0, 1'b1, 32'h0000_00FF);
    check("multi_pkt", pkt_count, 4'd1);
    check("multi_flit", flit_count, 4'd4);
    check("multi_hdr", last_header, 32'hA5A5_0011);

    // Protocol violations: body flit in IDLE, then header, header, tail.
    do_reset();
    send(1'b0, 1'b0, 32'hDEAD_0001);
    check("proto_err_first", proto_err, CHK);
    send(1'b1, 1'b0, 32'h1000_0001);
    send(1'b1, 1'b0, 32'h1000_0002);
    check("proto_err_sticky", proto_err, CHK);
    send(1'b0, 1'b1, 32'hDEAD_00FF);
    check("proto_pkt", pkt_count, 4'd1);
    check("proto_flit", flit_count, 4'd4);
    check("proto_err_end", proto_err, CHK);
    check("proto_hdr", last_header, 32'h1000_0002);

    // Saturation with 4-bit counters.
    do_reset();
    for (int i = 0; i < 20; i++) send(1'b1, 1'b1, 32'h5A00_0000 + 32'(i));
    check("sat_pkt", pkt_count, 4'd15);
    check("sat_flit", flit_count, 4'd15);
    check("sat_hdr", last_header, 32'h5A00_0013);

    // Reset in the middle of a packet.
    do_reset();
    send(1'b1, 1'b0, 32'h1234_0001);
    do_reset();
    send(1'b1, 1'b1, 32'h5678_0002);
    check("midrst_pkt", pkt_count, 4'd1);
    check("midrst_flit", flit_count, 4'd1);
    check("midrst_state", dut.u_tracker.state, NOC_PKT_IDLE);
    check("midrst_hdr", last_header, 32'h5678_0002);
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
